uart_alu_if: RTL and testbench
==============================

# uart_alu_if

Byte-to-command interface sitting directly downstream of the UART receiver and upstream of the UART transmitter. It consumes each received byte (data plus one-cycle done tick) and assembles three consecutive bytes into operand A, operand B and an opcode. It holds them stable on the ALU inputs, captures the combinational ALU result, and hands that result to the transmitter with a start/done handshake. It is the only sequencing logic between the serial link and the ALU.

## Interface
- NB_DATA, 8, width of received bytes, operands, result and tx data
- NB_OP, 6, opcode width; taken from the low NB_OP bits of the third byte
- TIMEOUT_TICKS, 50000000, inter-byte timeout in i_clk cycles; used only when IF_TIMEOUT_EN is defined; must be ≥ 2
- Clocking: one clock; reset is asynchronous and active-low.
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_rx_done_tick  in  1  one-cycle pulse from the receiver: i_rx_data is valid
- i_rx_data  in  NB_DATA  received byte
- i_alu_result  in  NB_DATA  combinational ALU output
- i_tx_done_tick  in  1  one-cycle pulse from the transmitter: frame finished
- o_alu_a  out  NB_DATA  operand A, registered
- o_alu_b  out  NB_DATA  operand B, registered
- o_alu_op  out  NB_OP  opcode, registered
- o_tx_start  out  1  one-cycle start pulse to the transmitter, registered
- o_tx_data  out  NB_DATA  byte to transmit, registered, stable from o_tx_start until the next capture
- o_rx_drop  out  1  one-cycle pulse: a byte arrived while busy and was discarded
- o_timeout  out  1  one-cycle pulse: assembly aborted by timeout; constant 0 without IF_TIMEOUT_EN

## Operation
- States:
  - S_OPA: wait for byte 1.
  - S_OPB: wait for byte 2.
  - S_OPCODE: wait for byte 3.
  - S_CALC: capture the ALU result.
  - S_TX: pulse start.
  - S_TXWAIT: wait for tx done.
- S_OPA, i_rx_done_tick → o_alu_a ← i_rx_data; → S_OPB.
- S_OPB, i_rx_done_tick → o_alu_b ← i_rx_data; → S_OPCODE.
- S_OPCODE, i_rx_done_tick → o_alu_op ← i_rx_data[NB_OP-1:0]; upper bits ignored; → S_CALC.
- S_CALC (exactly one cycle): o_tx_data ← i_alu_result; → S_TX.
- S_TX (exactly one cycle): o_tx_start = 1; → S_TXWAIT.
- S_TXWAIT, i_tx_done_tick → S_OPA. Without a done tick the block waits indefinitely.
- i_rx_done_tick in S_CALC, S_TX or S_TXWAIT: byte discarded, o_rx_drop = 1 the next cycle, state unchanged.
- o_alu_a/b/op hold their values until overwritten by a new byte; they are never cleared between commands.
- i_tx_done_tick outside S_TXWAIT is ignored.
- All outputs are registered. Reset values: state S_OPA; o_alu_a, o_alu_b, o_alu_op, o_tx_data = 0; o_tx_start, o_rx_drop, o_timeout = 0.
- Reset asserted mid-command aborts immediately. After release the block waits for byte 1 of a new command; no partial state survives.

## Timing
- Byte k captured on the i_clk edge where i_rx_done_tick is high; the output is visible the following cycle.
- Opcode capture edge → S_CALC one cycle later. The ALU has one full cycle with stable operands, so i_alu_result is sampled one cycle after the opcode is registered.
- o_tx_start is high exactly 2 cycles after the opcode capture edge, for 1 cycle.
- Minimum command turnaround is 3 cycles plus the transmitter frame time plus 1 cycle from the done tick back to S_OPA.
- Back-to-back i_rx_done_tick on consecutive cycles in S_OPA → S_OPB: both bytes are accepted.

## Configuration
- IF_TIMEOUT_EN defined:
  - A cycle counter runs in S_OPB and S_OPCODE.
  - It clears on every accepted byte and on entry from S_OPA.
  - When it reaches TIMEOUT_TICKS-1 with no byte: state → S_OPA and o_timeout pulses one cycle. Operands already captured are kept.
  - A byte arriving in the same cycle as expiry wins: it is accepted and there is no timeout.
- IF_TIMEOUT_EN undefined: no counter is built, the block waits indefinitely for bytes, and o_timeout is tied 0.

## Structure
- Shared package/include: state encodings (3-bit localparams S_OPA…S_TXWAIT) and default NB_DATA/NB_OP values shared with the ALU and UART top level.
- One sub-module: if_timeout_cnt (clear, enable, expire pulse; width $clog2(TIMEOUT_TICKS)), instantiated only under IF_TIMEOUT_EN.

## Test plan
- Basic add: send bytes 0x05, 0x03, opcode 0x20 with ALU model A+B → o_alu_a=0x05, o_alu_b=0x03, o_alu_op=0x20; o_tx_data=0x08; o_tx_start high 2 cycles after opcode capture.
- Opcode masking: third byte 0xE2 → o_alu_op=0x22.
- Busy drop: inject a byte 0x7F during S_TXWAIT → o_rx_drop pulses once; the next command's A is the next byte after i_tx_done_tick, not 0x7F.
- Back-to-back: two full commands with i_tx_done_tick 10 cycles after each start → two tx starts carrying correct results; no drops.
- Reset mid-command: assert i_reset_n=0 after byte 2 → all outputs 0, state S_OPA; a fresh 3-byte command completes normally.
- Timeout (IF_TIMEOUT_EN, TIMEOUT_TICKS=20):
  - Send byte 1 only → o_timeout pulses 20 cycles later and the next byte is treated as A.
  - A byte arriving exactly at expiry is accepted with no timeout pulse.

Source files
------------

// File: rtl/uart_alu_if_pkg.sv
// uart_alu_if shared definitions: FSM state encoding and default widths.
// Shared with the ALU and the UART top level.
package uart_alu_if_pkg;

  localparam int NB_DATA_DEF = 8;
  localparam int NB_OP_DEF   = 6;

  typedef enum logic [2:0] {
    S_OPA    = 3'd0,
    S_OPB    = 3'd1,
    S_OPCODE = 3'd2,
    S_CALC   = 3'd3,
    S_TX     = 3'd4,
    S_TXWAIT = 3'd5
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s == S_CALC) || (s == S_TX) || (s == S_TXWAIT);
  endfunction

endpackage

// File: rtl/uart_alu_if_timeout_cnt.sv
// if_timeout_cnt: inter-byte cycle counter with synchronous clear.
// Only instantiated when IF_TIMEOUT_EN is defined.
module if_timeout_cnt #(
  parameter int TIMEOUT_TICKS = 50000000
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int W = (TIMEOUT_TICKS > 2) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_TICKS - 1);

  logic [W-1:0] r_cnt;

  // count enabled cycles, restart on clear
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_en && (r_cnt == LAST);

endmodule

// File: rtl/uart_alu_if.sv
// uart_alu_if: assembles A, B, opcode from UART bytes, returns ALU result.
// Optional inter-byte timeout enabled by defining IF_TIMEOUT_EN.
module uart_alu_if
  import uart_alu_if_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_OP   = NB_OP_DEF
`ifdef IF_TIMEOUT_EN
  ,
  parameter int TIMEOUT_TICKS = 50000000
`endif
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_rx_done_tick,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done_tick,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_rx_drop,
  output logic               o_timeout
);

  state_t             r_state;
  logic [NB_DATA-1:0] r_alu_a;
  logic [NB_DATA-1:0] r_alu_b;
  logic [NB_OP-1:0]   r_alu_op;
  logic [NB_DATA-1:0] r_tx_data;
  logic               r_tx_start;
  logic               r_rx_drop;
  logic               r_timeout;
  logic               w_expire;

`ifdef IF_TIMEOUT_EN
  logic w_cnt_en;
  logic w_cnt_clr;

  assign w_cnt_en  = (r_state == S_OPB) || (r_state == S_OPCODE);
  assign w_cnt_clr = i_rx_done_tick || (r_state == S_OPA);

  if_timeout_cnt #(
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_timeout_cnt (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_clr    (w_cnt_clr),
    .i_en     (w_cnt_en),
    .o_expire (w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  // command sequencer with registered outputs
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= S_OPA;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_rx_drop  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_timeout  <= 1'b0;
      r_rx_drop  <= i_rx_done_tick && is_busy(r_state);
      unique case (r_state)
        S_OPA: begin
          if (i_rx_done_tick) begin
            r_alu_a <= i_rx_data;
            r_state <= S_OPB;
          end
        end
        S_OPB: begin
          if (i_rx_done_tick) begin
            r_alu_b <= i_rx_data;
            r_state <= S_OPCODE;
          end else if (w_expire) begin
            r_state   <= S_OPA;
            r_timeout <= 1'b1;
          end
        end
        S_OPCODE: begin
          if (i_rx_done_tick) begin
            r_alu_op <= i_rx_data[NB_OP-1:0];
            r_state  <= S_CALC;
          end else if (w_expire) begin
            r_state   <= S_OPA;
            r_timeout <= 1'b1;
          end
        end
        S_CALC: begin
          r_tx_data <= i_alu_result;
          r_state   <= S_TX;
        end
        S_TX: begin
          r_tx_start <= 1'b1;
          r_state    <= S_TXWAIT;
        end
        S_TXWAIT: begin
          if (i_tx_done_tick) begin
            r_state <= S_OPA;
          end
        end
        default: r_state <= S_OPA;
      endcase
    end
  end

  assign o_alu_a    = r_alu_a;
  assign o_alu_b    = r_alu_b;
  assign o_alu_op   = r_alu_op;
  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;
  assign o_rx_drop  = r_rx_drop;
  assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_uart_alu_if.sv
// tb_uart_alu_if: directed plus randomized command stream against a
// behavioural command/ALU model; define IF_TIMEOUT_EN for timeout cases.
module tb_uart_alu_if;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] alu_result;
  logic       tx_tick = 1'b0;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [5:0] alu_op;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       rx_drop;
  logic       timeout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_model(input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h02:   return a >> b[2:0];
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = alu_model(alu_a, alu_b, alu_op);

  uart_alu_if #(
    .NB_DATA(8),
    .NB_OP  (6)
`ifdef IF_TIMEOUT_EN
    ,
    .TIMEOUT_TICKS(20)
`endif
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_rx_done_tick(rx_tick),
    .i_rx_data     (rx_data),
    .i_alu_result  (alu_result),
    .i_tx_done_tick(tx_tick),
    .o_alu_a       (alu_a),
    .o_alu_b       (alu_b),
    .o_alu_op      (alu_op),
    .o_tx_start    (tx_start),
    .o_tx_data     (tx_data),
    .o_rx_drop     (rx_drop),
    .o_timeout     (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_tick = 1'b1;
    rx_data = b;
    tick();
    rx_tick = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a"}, alu_a, 0);
    chk({tag, "_b"}, alu_b, 0);
    chk({tag, "_op"}, alu_op, 0);
    chk({tag, "_txd"}, tx_data, 0);
    chk({tag, "_start"}, tx_start, 0);
    chk({tag, "_drop"}, rx_drop, 0);
    chk({tag, "_tmo"}, timeout, 0);
  endtask

  // one full command: bytes with gap idle cycles, result, start, done
  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] opb, input int gap,
                         input int wait_done, input bit drop);
    logic [7:0] exp;
    exp = alu_model(a, b, opb[5:0]);
    repeat (gap) tick();
    send(a);
    chk("byte_a", alu_a, a);
    repeat (gap) tick();
    chk("no_tmo_a", timeout, 0);
    send(b);
    chk("byte_b", alu_b, b);
    repeat (gap) tick();
    chk("no_tmo_b", timeout, 0);
    send(opb);
    chk("byte_op", alu_op, opb[5:0]);
    chk("start_early0", tx_start, 0);
    tick();
    chk("result", tx_data, exp);
    chk("start_early1", tx_start, 0);
    tick();
    chk("start", tx_start, 1);
    chk("result_at_start", tx_data, exp);
    for (int i = 0; i < wait_done; i++) begin
      if (drop && i == 0) begin
        rx_tick = 1'b1;
        rx_data = 8'h7F;
      end
      tick();
      rx_tick = 1'b0;
      chk("start_once", tx_start, 0);
      chk("drop", rx_drop, (drop && i == 0) ? 1 : 0);
    end
    tx_tick = 1'b1;
    tick();
    tx_tick = 1'b0;
    chk("result_hold", tx_data, exp);
    chk("drop_idle", rx_drop, 0);
  endtask

  logic [5:0] ops [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02};

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] ro;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    run_cmd(8'h05, 8'h03, 8'h20, 0, 4, 1'b0);
    chk("add_result", tx_data, 8'h08);
    chk("add_op", alu_op, 6'h20);

    run_cmd(8'h10, 8'h04, 8'hE2, 1, 3, 1'b0);
    chk("op_mask", alu_op, 6'h22);
    chk("sub_result", tx_data, 8'h0C);

    run_cmd(8'h21, 8'h42, 8'h25, 0, 5, 1'b1);
    run_cmd(8'h3C, 8'h0F, 8'h24, 0, 3, 1'b0);
    chk("after_drop_a", alu_a, 8'h3C);

    run_cmd(8'hC8, 8'h64, 8'h20, 0, 9, 1'b0);
    chk("b2b_1", tx_data, 8'h2C);
    run_cmd(8'h09, 8'h0A, 8'h26, 0, 9, 1'b0);
    chk("b2b_2", tx_data, 8'h03);

    send(8'hAA);
    send(8'h55);
    rst_n = 1'b0;
    #2;
    chk_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_cmd(8'h07, 8'h02, 8'h02, 0, 2, 1'b0);
    chk("post_reset", tx_data, 8'h01);

`ifdef IF_TIMEOUT_EN
    send(8'hA1);
    for (int i = 0; i < 19; i++) begin
      tick();
      chk("tmo_early", timeout, 0);
    end
    tick();
    chk("tmo_pulse", timeout, 1);
    tick();
    chk("tmo_once", timeout, 0);
    chk("tmo_keep_a", alu_a, 8'hA1);
    run_cmd(8'h13, 8'h01, 8'h20, 0, 2, 1'b0);
    chk("tmo_next_a", alu_a, 8'h13);

    send(8'h11);
    repeat (19) tick();
    send(8'h22);
    chk("expiry_b", alu_b, 8'h22);
    chk("expiry_no_tmo", timeout, 0);
    send(8'h20);
    chk("expiry_op", alu_op, 6'h20);
    tick();
    tick();
    chk("expiry_start", tx_start, 1);
    chk("expiry_result", tx_data, 8'h33);
    tx_tick = 1'b1;
    tick();
    tx_tick = 1'b0;
`else
    run_cmd(8'h44, 8'h11, 8'h22, 30, 2, 1'b0);
    chk("no_tmo_long", tx_data, 8'h33);
`endif

    for (int n = 0; n < 25; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      ro = {2'($urandom), ops[$urandom_range(0, 6)]};
      run_cmd(ra, rb, ro, $urandom_range(0, 3), $urandom_range(2, 12),
              1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
